// File: rtl/lsu_ctrl.sv
// Load/store sequencer: effective-address generation, req/ack memory handshake and load extension.
// Optional define MISALIGN_TRAP_EN traps misaligned half/word accesses with err_code 2'b10.
module lsu_ctrl #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] base,
  input  logic [31:0] imm,
  input  logic [31:0] store_data,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        stall,
  output logic        done,
  output logic [31:0] load_data,
  output logic        err,
  output logic [1:0]  err_code
);

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  localparam logic [7:0] CntLast = 8'(TIMEOUT - 1);

  state_e      state;
  logic [7:0]  cnt;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic        store_q;

  logic [31:0] ea;
  logic        legal;
  logic        misalign;
  logic [3:0]  be_new;
  logic [31:0] wdata_new;
  logic [31:0] byte_sh;
  logic [31:0] half_sh;
  logic [31:0] ld_ext;

  always_comb begin
    ea = base + imm;
    case (funct3)
      3'b000, 3'b001, 3'b010: legal = 1'b1;
      3'b100, 3'b101:         legal = ~is_store;
      default:                legal = 1'b0;
    endcase
    misalign = 1'b0;
`ifdef MISALIGN_TRAP_EN
    case (funct3[1:0])
      2'b01:   misalign = ea[0];
      2'b10:   misalign = |ea[1:0];
      default: misalign = 1'b0;
    endcase
`endif
    case (funct3[1:0])
      2'b00: begin
        be_new    = 4'b0001 << ea[1:0];
        wdata_new = {4{store_data[7:0]}};
      end
      2'b01: begin
        be_new    = 4'b0011 << {ea[1], 1'b0};
        wdata_new = {2{store_data[15:0]}};
      end
      default: begin
        be_new    = 4'b1111;
        wdata_new = store_data;
      end
    endcase
  end

  // Lane extraction uses the offset latched at acceptance, not the live inputs.
  always_comb begin
    byte_sh = mem_rdata >> {off_q, 3'b000};
    half_sh = mem_rdata >> {off_q[1], 4'b0000};
    case (f3_q)
      3'b000:  ld_ext = {{24{byte_sh[7]}}, byte_sh[7:0]};
      3'b100:  ld_ext = {24'h000000, byte_sh[7:0]};
      3'b001:  ld_ext = {{16{half_sh[15]}}, half_sh[15:0]};
      3'b101:  ld_ext = {16'h0000, half_sh[15:0]};
      default: ld_ext = mem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= StIdle;
      cnt       <= 8'd0;
      f3_q      <= 3'b000;
      off_q     <= 2'b00;
      store_q   <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'h0;
      mem_wdata <= 32'h0;
      mem_be    <= 4'h0;
      stall     <= 1'b0;
      done      <= 1'b0;
      load_data <= 32'h0;
      err       <= 1'b0;
      err_code  <= 2'b00;
    end else begin
      case (state)
        StIdle: begin
          if (start) begin
            stall <= 1'b1;
            if (!legal || misalign) begin
              state     <= StDone;
              done      <= 1'b1;
              err       <= 1'b1;
              err_code  <= legal ? 2'b10 : 2'b01;
              load_data <= 32'h0;
            end else begin
              state     <= StAccess;
              cnt       <= 8'd0;
              f3_q      <= funct3;
              off_q     <= ea[1:0];
              store_q   <= is_store;
              mem_req   <= 1'b1;
              mem_we    <= is_store;
              mem_addr  <= {ea[31:2], 2'b00};
              mem_be    <= be_new;
              mem_wdata <= wdata_new;
            end
          end
        end
        StAccess: begin
          // An ack in the final counted cycle takes priority over the timeout.
          if (mem_ack) begin
            state     <= StDone;
            mem_req   <= 1'b0;
            done      <= 1'b1;
            load_data <= store_q ? 32'h0 : ld_ext;
          end else if (cnt == CntLast) begin
            state     <= StDone;
            mem_req   <= 1'b0;
            done      <= 1'b1;
            err       <= 1'b1;
            err_code  <= 2'b11;
            load_data <= 32'h0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        StDone: begin
          state    <= StIdle;
          done     <= 1'b0;
          stall    <= 1'b0;
          err      <= 1'b0;
          err_code <= 2'b00;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
